mem_access_unit: RTL and testbench

//  MEM-stage load/store unit directly upstream of the word-only data memory. Turns

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the MEM stage, the load/store unit and the data memory.
// slave: load/store unit side; master: pipeline plus data-memory side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_rd;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic              mem_signed;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata_out;
    logic              stall;
    logic              misalign;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    modport slave (
        input  mem_rd, mem_wr, mem_size, mem_signed, addr, wdata, dm_rdata,
        output rdata_out, stall, misalign, dm_rd, dm_wr, dm_addr, dm_wdata
    );

    modport master (
        output mem_rd, mem_wr, mem_size, mem_signed, addr, wdata, dm_rdata,
        input  rdata_out, stall, misalign, dm_rd, dm_wr, dm_addr, dm_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only data memory.
// Ports: clk, reset (async, active-high), bus (request, load result, stall, dm_* memory side).
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t            state, state_nxt;
    logic [31:0]       merged_q, merged_d;
    logic [ADDR_W-1:0] addr_q, word_addr;
    logic              capture, aligned, sub_word;
    logic [4:0]        byte_sh, half_sh;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    logic [31:0]       rdata_out, dm_wdata;
    logic [ADDR_W-1:0] dm_addr;
    logic              stall, misalign, dm_rd, dm_wr;

    assign word_addr = {bus.addr[ADDR_W-1:2], 2'b00};
    assign byte_sh   = {bus.addr[1:0], 3'b000};
    assign half_sh   = {bus.addr[1], 4'b0000};
    assign byte_sel  = bus.dm_rdata[byte_sh +: 8];
    assign half_sel  = bus.dm_rdata[half_sh +: 16];
    // Size 00/01 are sub-word; 10 and reserved 11 behave as word.
    assign sub_word  = ~bus.mem_size[1];

    always_comb begin
        aligned = 1'b1;
        case (bus.mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~bus.addr[0];
            default: aligned = (bus.addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        load_ext = bus.dm_rdata;
        case (bus.mem_size)
            2'b00:   load_ext = {{24{bus.mem_signed & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{bus.mem_signed & half_sel[15]}}, half_sel};
            default: load_ext = bus.dm_rdata;
        endcase
    end

    // Read-modify-write merge: current memory word with the store lane replaced.
    always_comb begin
        merged_d = bus.dm_rdata;
        if (bus.mem_size[0])
            merged_d[half_sh +: 16] = bus.wdata[15:0];
        else
            merged_d[byte_sh +: 8] = bus.wdata[7:0];
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        rdata_out = '0;
        stall     = 1'b0;
        misalign  = 1'b0;
        dm_rd     = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        // Reset forces every output low, including a pending RMW write.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (bus.mem_rd || bus.mem_wr) begin
                        if (!aligned) begin
                            misalign = 1'b1;
                        end else if (bus.mem_wr) begin
                            dm_addr = word_addr;
                            if (sub_word) begin
                                dm_rd     = 1'b1;
                                stall     = 1'b1;
                                capture   = 1'b1;
                                state_nxt = RMW_WR;
                            end else begin
                                dm_wr    = 1'b1;
                                dm_wdata = bus.wdata;
                            end
                        end else begin
                            dm_rd     = 1'b1;
                            dm_addr   = word_addr;
                            rdata_out = load_ext;
                        end
                    end
                end
                RMW_WR: begin
                    dm_wr     = 1'b1;
                    dm_addr   = addr_q;
                    dm_wdata  = merged_q;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            merged_q <= '0;
            addr_q   <= '0;
        end else if (capture) begin
            merged_q <= merged_d;
            addr_q   <= word_addr;
        end
    end

    assign bus.rdata_out = rdata_out;
    assign bus.stall     = stall;
    assign bus.misalign  = misalign;
    assign bus.dm_rd     = dm_rd;
    assign bus.dm_wr     = dm_wr;
    assign bus.dm_addr   = dm_addr;
    assign bus.dm_wdata  = dm_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory and a scoreboard.
// Ports: none; drives the unit through mem_access_unit_if.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset;
    logic mem_clr, pre_we;
    logic [3:0] pre_idx;
    logic [31:0] pre_data;
    logic [31:0] mem [16];
    logic [31:0] sb_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.dm_rdata = mem[bus.dm_addr[5:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.dm_wr) begin
            mem[bus.dm_addr[5:2]] <= bus.dm_wdata;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit rd, bit wr, logic [1:0] sz, bit sg,
                         logic [31:0] a, logic [31:0] wd);
        bus.mem_rd     = rd;
        bus.mem_wr     = wr;
        bus.mem_size   = sz;
        bus.mem_signed = sg;
        bus.addr       = a;
        bus.wdata      = wd;
    endtask

    function automatic logic [31:0] model_load(logic [31:0] w, int off, int sz, bit sg);
        logic [7:0] b [4];
        logic [15:0] h;
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        if (sz == 0)
            return (sg && b[off][7]) ? {24'hFFFFFF, b[off]} : {24'h0, b[off]};
        if (sz == 1) begin
            h = {b[off+1], b[off]};
            return (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        end
        return w;
    endfunction

    task automatic load(string tag, logic [31:0] a, logic [1:0] sz, bit sg,
                        logic [31:0] exp);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        @(negedge clk);
        drive(1, 0, sz, sg, a, 32'h0);
        sb_q.push_back(exp);
        #1;
        chk({tag, "_dm_rd"}, 32'(bus.dm_rd), 32'h1);
        chk({tag, "_dm_addr"}, bus.dm_addr, wa);
        chk(tag, bus.rdata_out, sb_q.pop_front());
    endtask

    task automatic mis(string tag, logic [31:0] a, logic [1:0] sz, bit rd, bit wr);
        @(negedge clk);
        drive(rd, wr, sz, 1'b1, a, 32'hFFFF_FFFF);
        #1;
        chk({tag, "_misalign"}, 32'(bus.misalign), 32'h1);
        chk({tag, "_dm_rd"}, 32'(bus.dm_rd), 32'h0);
        chk({tag, "_dm_wr"}, 32'(bus.dm_wr), 32'h0);
        chk({tag, "_stall"}, 32'(bus.stall), 32'h0);
        chk({tag, "_rdata"}, bus.rdata_out, 32'h0);
    endtask

    task automatic store_word(string tag, logic [31:0] a, logic [31:0] wd);
        @(negedge clk);
        drive(0, 1, 2'b10, 0, a, wd);
        sb_q.push_back(wd);
        #1;
        chk({tag, "_dm_wr"}, 32'(bus.dm_wr), 32'h1);
        chk({tag, "_stall"}, 32'(bus.stall), 32'h0);
        chk({tag, "_dm_wdata"}, bus.dm_wdata, sb_q.pop_front());
        @(negedge clk);
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        #1;
        chk({tag, "_wr_one_cycle"}, 32'(bus.dm_wr), 32'h0);
    endtask

    task automatic store_sub(string tag, logic [31:0] a, logic [1:0] sz,
                             logic [31:0] wd, logic [31:0] exp_word);
        @(negedge clk);
        drive(0, 1, sz, 0, a, wd);
        sb_q.push_back(exp_word);
        #1;
        chk({tag, "_c1_stall"}, 32'(bus.stall), 32'h1);
        chk({tag, "_c1_dm_wr"}, 32'(bus.dm_wr), 32'h0);
        chk({tag, "_c1_dm_rd"}, 32'(bus.dm_rd), 32'h1);
        @(negedge clk);
        #1;
        chk({tag, "_c2_stall"}, 32'(bus.stall), 32'h0);
        chk({tag, "_c2_dm_wr"}, 32'(bus.dm_wr), 32'h1);
        chk({tag, "_c2_dm_rd"}, 32'(bus.dm_rd), 32'h0);
        chk({tag, "_c2_dm_addr"}, bus.dm_addr, {a[31:2], 2'b00});
        chk({tag, "_c2_dm_wdata"}, bus.dm_wdata, sb_q.pop_front());
    endtask

    initial begin
        logic [31:0] ref_word;
        bit ok;
        reset   = 1'b1;
        mem_clr = 1'b1;
        pre_we  = 1'b0;
        pre_idx = '0;
        pre_data = '0;
        drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rdata", bus.rdata_out, 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'h0);
        chk("rst_dm_rd", 32'(bus.dm_rd), 32'h0);
        chk("rst_dm_wr", 32'(bus.dm_wr), 32'h0);
        chk("rst_dm_addr", bus.dm_addr, 32'h0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'h0);

        @(negedge clk);
        reset   = 1'b0;
        mem_clr = 1'b0;
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        ref_word = 32'h8899AABB;
        pre_we   = 1'b1;
        pre_idx  = 4'd4;
        pre_data = ref_word;
        @(negedge clk);
        pre_we = 1'b0;

        load("lb_13", 32'h13, 2'b00, 1, 32'hFFFFFF88);
        load("lbu_13", 32'h13, 2'b00, 0, 32'h00000088);
        load("lh_12", 32'h12, 2'b01, 1, 32'hFFFF8899);
        load("lhu_10", 32'h10, 2'b01, 0, 32'h0000AABB);
        mis("lh_11", 32'h11, 2'b01, 1, 0);

        for (int off = 0; off < 4; off++) begin
            for (int sz = 0; sz < 4; sz++) begin
                for (int sg = 0; sg < 2; sg++) begin
                    ok = (sz == 0) || (sz == 1 && off[0] == 1'b0) || (off == 0);
                    if (ok)
                        load($sformatf("ld_o%0d_s%0d_g%0d", off, sz, sg),
                             32'h10 + 32'(off), 2'(sz), 1'(sg),
                             model_load(ref_word, off, sz, 1'(sg)));
                    else
                        mis($sformatf("mis_o%0d_s%0d", off, sz),
                            32'h10 + 32'(off), 2'(sz), 1, 0);
                end
            end
        end

        mis("sw_mis", 32'h06, 2'b10, 0, 1);
        mis("sh_mis", 32'h07, 2'b01, 0, 1);

        store_word("sw_04", 32'h04, 32'h11223344);
        load("lw_04a", 32'h04, 2'b10, 0, 32'h11223344);

        store_sub("sb_05", 32'h05, 2'b00, 32'h000000EE, 32'h1122EE44);
        load("lw_04b", 32'h04, 2'b10, 0, 32'h1122EE44);

        store_sub("sh_06", 32'h06, 2'b01, 32'h0000CAFE, 32'hCAFEEE44);
        store_sub("sb_04", 32'h04, 2'b00, 32'h0000007F, 32'hCAFEEE7F);
        load("lw_04c", 32'h04, 2'b10, 0, 32'hCAFEEE7F);

        @(negedge clk);
        drive(1, 1, 2'b10, 0, 32'h08, 32'hDEADBEEF);
        #1;
        chk("rdwr_dm_wr", 32'(bus.dm_wr), 32'h1);
        chk("rdwr_dm_rd", 32'(bus.dm_rd), 32'h0);
        chk("rdwr_rdata", bus.rdata_out, 32'h0);
        load("lw_08", 32'h08, 2'b10, 0, 32'hDEADBEEF);

        @(negedge clk);
        drive(0, 1, 2'b00, 0, 32'h04, 32'h00000055);
        #1;
        chk("rst_rmw_c1_stall", 32'(bus.stall), 32'h1);
        @(negedge clk);
        #1;
        chk("rst_rmw_c2_dm_wr", 32'(bus.dm_wr), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_rmw_dm_wr_drop", 32'(bus.dm_wr), 32'h0);
        chk("rst_rmw_dm_wdata", bus.dm_wdata, 32'h0);
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_stall", 32'(bus.stall), 32'h0);
        chk("post_rst_dm_wr", 32'(bus.dm_wr), 32'h0);
        load("lw_04d", 32'h04, 2'b10, 0, 32'hCAFEEE7F);

        @(negedge clk);
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        #1;
        chk("idle_dm_rd", 32'(bus.dm_rd), 32'h0);
        chk("idle_rdata", bus.rdata_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
